// File: rtl/axi_sub_arb_rr.sv
// axi_sub_arb_rr: N-way round-robin/fixed-priority arbiter in front of one component.
// A burst holds the grant until its last beat; read returns follow a fixed C_LAT pipe.
module axi_sub_arb_rr #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int UW       = 32,
   parameter int IW       = 1,
   parameter int N        = 2,
   parameter int ARB_MODE = 0,
   parameter int C_LAT    = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       req_dv,
   input  logic [N-1:0]       req_write,
   input  logic [N*AW-1:0]    req_addr,
   input  logic [N*UW-1:0]    req_user,
   input  logic [N*IW-1:0]    req_id,
   input  logic [N*DW-1:0]    req_wdata,
   input  logic [N*DW/8-1:0]  req_wstrb,
   input  logic [N-1:0]       req_last,
   output logic [N-1:0]       req_hld,
   output logic [N-1:0]       req_err,
   output logic [N-1:0]       req_rvalid,
   output logic [DW-1:0]      req_rdata,
   output logic               dv,
   output logic [AW-1:0]      addr,
   output logic               write,
   output logic [UW-1:0]      user,
   output logic [IW-1:0]      id,
   output logic [DW-1:0]      wdata,
   output logic [DW/8-1:0]    wstrb,
   output logic               last,
   input  logic               hld,
   input  logic               rd_err,
   input  logic               wr_err,
   input  logic [DW-1:0]      rdata
);
   localparam int BC = DW / 8;
   localparam int NW = $clog2(N);

   logic          lock_vld_q, lock_vld_d;
   logic [NW-1:0] lock_idx_q, lock_idx_d, ptr_q, ptr_d;
   logic [NW-1:0] gnt, rv_idx;
   logic          gnt_vld, acc, rd_acc, rv_vld;

   // Earliest match wins, so scan from the far end and let nearer hits overwrite.
   always_comb begin
      logic [NW-1:0] c;
      gnt = lock_idx_q;
      gnt_vld = lock_vld_q;
      c = '0;
      if (!lock_vld_q)
         for (int k = N - 1; k >= 0; k--) begin
            c = NW'((k + (ARB_MODE == 0 ? int'(ptr_q) : 0)) % N);
            if (req_dv[c]) begin
               gnt = c;
               gnt_vld = 1'b1;
            end
         end
   end

   always_comb begin
      addr  = req_addr[AW-1:0];
      write = req_write[0];
      user  = req_user[UW-1:0];
      id    = req_id[IW-1:0];
      wdata = req_wdata[DW-1:0];
      wstrb = req_wstrb[BC-1:0];
      last  = req_last[0];
      for (int i = 1; i < N; i++)
         if (gnt_vld && gnt == NW'(i)) begin
            addr  = req_addr[i*AW +: AW];
            write = req_write[i];
            user  = req_user[i*UW +: UW];
            id    = req_id[i*IW +: IW];
            wdata = req_wdata[i*DW +: DW];
            wstrb = req_wstrb[i*BC +: BC];
            last  = req_last[i];
         end
   end

   always_comb begin
      for (int i = 0; i < N; i++)
         req_hld[i] = hld || !(gnt_vld && gnt == NW'(i));
   end

   assign dv        = gnt_vld && req_dv[gnt];
   assign acc       = dv && !hld;
   assign rd_acc    = acc && !write;
   assign req_rdata = rdata;

   always_comb begin
      lock_vld_d = lock_vld_q;
      lock_idx_d = lock_idx_q;
      ptr_d      = ptr_q;
      if (dv) begin
         lock_vld_d = hld || !last;
         lock_idx_d = gnt;
      end
      if (acc && last && ARB_MODE == 0)
         ptr_d = (gnt == NW'(N - 1)) ? '0 : gnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_vld_q <= 1'b0;
         lock_idx_q <= '0;
         ptr_q      <= '0;
      end else begin
         lock_vld_q <= lock_vld_d;
         lock_idx_q <= lock_idx_d;
         ptr_q      <= ptr_d;
      end
   end

   if (C_LAT == 0) begin : g_comb
      assign rv_vld = rd_acc;
      assign rv_idx = gnt;
   end else begin : g_pipe
      logic [C_LAT-1:0] pv_q;
      logic [NW-1:0]    pi_q [C_LAT];
      always_ff @(posedge clk) begin
         pi_q[0] <= gnt;
         for (int s = 1; s < C_LAT; s++) pi_q[s] <= pi_q[s-1];
         if (rst) pv_q <= '0;
         else begin
            pv_q[0] <= rd_acc;
            for (int s = 1; s < C_LAT; s++) pv_q[s] <= pv_q[s-1];
         end
      end
      assign rv_vld = pv_q[C_LAT-1];
      assign rv_idx = pi_q[C_LAT-1];
   end

   // A read return and a write error can land on different requesters in one cycle.
   assign req_rvalid = rv_vld ? (N'(1) << rv_idx) : '0;
   assign req_err    = ((rv_vld && rd_err) ? (N'(1) << rv_idx) : '0) |
                       ((acc && write && wr_err) ? (N'(1) << gnt) : '0);
endmodule

// File: tb/tb_axi_sub_arb_rr.sv
// tb_axi_sub_arb_rr: vector tables for a 4-way round-robin (C_LAT=2) and a
// 3-way fixed-priority (C_LAT=0) instance.
module tb_axi_sub_arb_rr;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic [3:0]  dv, wr, last;
      logic        hld, rde, wre;
      logic [3:0]  x_hld;
      logic        x_dv;
      logic [31:0] x_addr;
      logic [3:0]  x_rv, x_err;
   } vec_t;

   function automatic vec_t mk(logic r, logic [3:0] d, logic [3:0] w, logic [3:0] l,
                               logic h, logic re, logic we, logic [3:0] xh, logic xd,
                               logic [31:0] xa, logic [3:0] xr, logic [3:0] xe);
      vec_t v;
      v.rst = r; v.dv = d; v.wr = w; v.last = l; v.hld = h; v.rde = re; v.wre = we;
      v.x_hld = xh; v.x_dv = xd; v.x_addr = xa; v.x_rv = xr; v.x_err = xe;
      return v;
   endfunction

   task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %h expected %h", nm, k, act, exp);
      end
   endtask

   // Instance A: N=4, round-robin, C_LAT=2
   logic [3:0]   a_dv = '0, a_wr = '0, a_last = '0;
   logic         a_hld = 1'b0, a_rde = 1'b0, a_wre = 1'b0;
   logic [127:0] a_addr_i, a_wdata_i;
   logic [127:0] a_user_i = '0;
   logic [3:0]   a_id_i = '0;
   logic [15:0]  a_wstrb_i = '1;
   logic [3:0]   a_req_hld, a_req_err, a_req_rvalid;
   logic [31:0]  a_req_rdata, a_addr, a_user, a_wdata;
   logic         a_dvo, a_write, a_lasto;
   logic [0:0]   a_id;
   logic [3:0]   a_wstrb;
   logic [31:0]  rdata = 32'hCAFE_0001;

   axi_sub_arb_rr #(.N(4), .ARB_MODE(0), .C_LAT(2)) u_a (
      .clk(clk), .rst(rst), .req_dv(a_dv), .req_write(a_wr), .req_addr(a_addr_i),
      .req_user(a_user_i), .req_id(a_id_i), .req_wdata(a_wdata_i), .req_wstrb(a_wstrb_i),
      .req_last(a_last), .req_hld(a_req_hld), .req_err(a_req_err), .req_rvalid(a_req_rvalid),
      .req_rdata(a_req_rdata), .dv(a_dvo), .addr(a_addr), .write(a_write), .user(a_user),
      .id(a_id), .wdata(a_wdata), .wstrb(a_wstrb), .last(a_lasto), .hld(a_hld),
      .rd_err(a_rde), .wr_err(a_wre), .rdata(rdata));

   // Instance B: N=3, fixed priority, C_LAT=0
   logic [2:0]  b_dv = '0, b_wr = '0, b_last = '0;
   logic        b_hld = 1'b0, b_rde = 1'b0, b_wre = 1'b0;
   logic [95:0] b_addr_i, b_wdata_i;
   logic [95:0] b_user_i = '0;
   logic [2:0]  b_id_i = '0;
   logic [11:0] b_wstrb_i = '1;
   logic [2:0]  b_req_hld, b_req_err, b_req_rvalid;
   logic [31:0] b_req_rdata, b_addr, b_user, b_wdata;
   logic        b_dvo, b_write, b_lasto;
   logic [0:0]  b_id;
   logic [3:0]  b_wstrb;

   axi_sub_arb_rr #(.N(3), .ARB_MODE(1), .C_LAT(0)) u_b (
      .clk(clk), .rst(rst), .req_dv(b_dv), .req_write(b_wr), .req_addr(b_addr_i),
      .req_user(b_user_i), .req_id(b_id_i), .req_wdata(b_wdata_i), .req_wstrb(b_wstrb_i),
      .req_last(b_last), .req_hld(b_req_hld), .req_err(b_req_err), .req_rvalid(b_req_rvalid),
      .req_rdata(b_req_rdata), .dv(b_dvo), .addr(b_addr), .write(b_write), .user(b_user),
      .id(b_id), .wdata(b_wdata), .wstrb(b_wstrb), .last(b_lasto), .hld(b_hld),
      .rd_err(b_rde), .wr_err(b_wre), .rdata(rdata));

   initial begin
      for (int i = 0; i < 4; i++) begin
         a_addr_i[i*32 +: 32]  = 32'h100 * (i + 1);
         a_wdata_i[i*32 +: 32] = 32'hD000 + i;
      end
      for (int i = 0; i < 3; i++) begin
         b_addr_i[i*32 +: 32]  = 32'h100 * (i + 1);
         b_wdata_i[i*32 +: 32] = 32'hE000 + i;
      end
   end

   task automatic run_a(input vec_t v, input int k);
      @(negedge clk);
      rst = v.rst; a_dv = v.dv; a_wr = v.wr; a_last = v.last;
      a_hld = v.hld; a_rde = v.rde; a_wre = v.wre;
      #1;
      chk("a_req_hld", k, {28'd0, a_req_hld}, {28'd0, v.x_hld});
      chk("a_dv", k, {31'd0, a_dvo}, {31'd0, v.x_dv});
      chk("a_addr", k, a_addr, v.x_addr);
      chk("a_req_rvalid", k, {28'd0, a_req_rvalid}, {28'd0, v.x_rv});
      chk("a_req_err", k, {28'd0, a_req_err}, {28'd0, v.x_err});
   endtask

   task automatic run_b(input vec_t v, input int k);
      @(negedge clk);
      rst = v.rst; b_dv = v.dv[2:0]; b_wr = v.wr[2:0]; b_last = v.last[2:0];
      b_hld = v.hld; b_rde = v.rde; b_wre = v.wre;
      #1;
      chk("b_req_hld", k, {29'd0, b_req_hld}, {28'd0, v.x_hld});
      chk("b_dv", k, {31'd0, b_dvo}, {31'd0, v.x_dv});
      chk("b_addr", k, b_addr, v.x_addr);
      chk("b_req_rvalid", k, {29'd0, b_req_rvalid}, {28'd0, v.x_rv});
      chk("b_req_err", k, {29'd0, b_req_err}, {28'd0, v.x_err});
   endtask

   vec_t va [21];
   vec_t vb [8];

   initial begin
      // rst dv wr last hld rde wre | x_hld x_dv x_addr x_rv x_err
      va[0]  = mk(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'hF, 0, 32'h100, 4'h0, 4'h0);
      va[1]  = mk(0, 4'hF, 4'h0, 4'hF, 0, 0, 0, 4'hE, 1, 32'h100, 4'h0, 4'h0);
      va[2]  = mk(0, 4'hF, 4'h0, 4'hF, 0, 0, 0, 4'hD, 1, 32'h200, 4'h0, 4'h0);
      va[3]  = mk(0, 4'hF, 4'h0, 4'hF, 0, 0, 0, 4'hB, 1, 32'h300, 4'h1, 4'h0);
      va[4]  = mk(0, 4'hF, 4'h0, 4'hF, 0, 1, 0, 4'h7, 1, 32'h400, 4'h2, 4'h2);
      va[5]  = mk(0, 4'hF, 4'h0, 4'hF, 0, 0, 0, 4'hE, 1, 32'h100, 4'h4, 4'h0);
      va[6]  = mk(0, 4'h0, 4'h0, 4'h0, 0, 1, 0, 4'hF, 0, 32'h100, 4'h8, 4'h8);
      va[7]  = mk(0, 4'h4, 4'h4, 4'h0, 0, 0, 1, 4'hB, 1, 32'h300, 4'h1, 4'h4);
      va[8]  = mk(0, 4'h6, 4'h4, 4'h0, 1, 0, 0, 4'hF, 1, 32'h300, 4'h0, 4'h0);
      va[9]  = mk(0, 4'h6, 4'h4, 4'h0, 1, 0, 0, 4'hF, 1, 32'h300, 4'h0, 4'h0);
      va[10] = mk(0, 4'h2, 4'h4, 4'h0, 0, 0, 0, 4'hB, 0, 32'h300, 4'h0, 4'h0);
      va[11] = mk(0, 4'h6, 4'h4, 4'h4, 0, 0, 0, 4'hB, 1, 32'h300, 4'h0, 4'h0);
      va[12] = mk(0, 4'h2, 4'h0, 4'h2, 0, 0, 0, 4'hD, 1, 32'h200, 4'h0, 4'h0);
      va[13] = mk(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'hF, 0, 32'h100, 4'h0, 4'h0);
      va[14] = mk(0, 4'h0, 4'h0, 4'h0, 0, 1, 0, 4'hF, 0, 32'h100, 4'h2, 4'h2);
      va[15] = mk(0, 4'h1, 4'h0, 4'h1, 0, 0, 0, 4'hE, 1, 32'h100, 4'h0, 4'h0);
      va[16] = mk(0, 4'h8, 4'h0, 4'h0, 0, 0, 0, 4'h7, 1, 32'h400, 4'h0, 4'h0);
      va[17] = mk(1, 4'h8, 4'h0, 4'h0, 0, 0, 0, 4'h7, 1, 32'h400, 4'h1, 4'h0);
      va[18] = mk(0, 4'h9, 4'h0, 4'h9, 0, 0, 0, 4'hE, 1, 32'h100, 4'h0, 4'h0);
      va[19] = mk(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'hF, 0, 32'h100, 4'h0, 4'h0);
      va[20] = mk(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'hF, 0, 32'h100, 4'h1, 4'h0);

      vb[0]  = mk(0, 4'h6, 4'h0, 4'h6, 0, 0, 0, 4'h5, 1, 32'h200, 4'h2, 4'h0);
      vb[1]  = mk(0, 4'h6, 4'h0, 4'h6, 0, 1, 0, 4'h5, 1, 32'h200, 4'h2, 4'h2);
      vb[2]  = mk(0, 4'h7, 4'h0, 4'h7, 0, 0, 0, 4'h6, 1, 32'h100, 4'h1, 4'h0);
      vb[3]  = mk(0, 4'h6, 4'h6, 4'h6, 0, 0, 1, 4'h5, 1, 32'h200, 4'h0, 4'h2);
      vb[4]  = mk(0, 4'h4, 4'h0, 4'h4, 0, 0, 0, 4'h3, 1, 32'h300, 4'h4, 4'h0);
      vb[5]  = mk(0, 4'h4, 4'h0, 4'h4, 1, 1, 0, 4'h7, 1, 32'h300, 4'h0, 4'h0);
      vb[6]  = mk(0, 4'h7, 4'h0, 4'h7, 0, 0, 0, 4'h3, 1, 32'h300, 4'h4, 4'h0);
      vb[7]  = mk(0, 4'h3, 4'h0, 4'h3, 0, 0, 0, 4'h6, 1, 32'h100, 4'h1, 4'h0);

      repeat (2) @(posedge clk);
      for (int k = 0; k < 21; k++) run_a(va[k], k);
      @(negedge clk);
      a_dv = '0;
      chk("a_req_rdata", 0, a_req_rdata, 32'hCAFE_0001);
      for (int k = 0; k < 8; k++) run_b(vb[k], k);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
